// File: rtl/perm_host_agent.sv
// perm_host_agent
// Host-side responder for the permutation control unit. Holds a DEPTH-slice
// input frame loaded by the host, kicks the controller with a two-cycle
// start pulse, serves one input slice per read_input request and captures
// one result slice per write_output strobe. The captured result frame is
// readable by the host at all times; done reports a finished frame.
//
// Optional build macro: PERM_HOST_WATCHDOG_EN
//   defined   -> 8-bit idle counter in RUN; TIMEOUT idle cycles set err and
//                force DONE.
//   undefined -> RUN waits indefinitely for DEPTH captures.
//
// Ports
//   clk, reset          : rising-edge clock, async active-low reset
//   host_we/waddr/wdata : input frame write port (ignored while busy)
//   host_raddr/rdata    : result frame read port (combinational)
//   go                  : run request (accepted in IDLE or DONE)
//   busy, done, err     : status; err sticky until next accepted go
//   start               : registered start pulse to the controller
//   read_input          : controller fetches next input slice (slice_out)
//   write_output        : controller strobes a result slice (slice_in)
module perm_host_agent #(
  parameter int SLICE_W = 25,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_waddr,
  input  logic [SLICE_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0]  host_raddr,
  output logic [SLICE_W-1:0] host_rdata,
  input  logic               go,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               start,
  input  logic               read_input,
  output logic [SLICE_W-1:0] slice_out,
  input  logic               write_output,
  input  logic [SLICE_W-1:0] slice_in
);

  localparam int              START_LEN = 2;
  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit idle counter");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t state, state_nxt;

  logic [SLICE_W-1:0] in_buf  [DEPTH];
  logic [SLICE_W-1:0] out_buf [DEPTH];

  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   rd_cnt, wr_cnt;
  logic [1:0]        st_cnt;
  logic              start_r, err_r;

  logic go_acc, rd_fire, wr_fire, rd_over, wr_early, wr_last, wd_trip;

  // ---------------- status decode ----------------
  assign busy  = (state == START) || (state == RUN);
  assign done  = (state == DONE);
  assign start = start_r;
  assign err   = err_r;

  assign go_acc   = go && ((state == IDLE) || (state == DONE));
  assign rd_fire  = read_input   && (state == RUN);
  assign wr_fire  = write_output && (state == RUN);
  // A read past the end of the frame is flagged and otherwise dropped,
  // so rd_ptr parks at 0 and rd_cnt never exceeds DEPTH.
  assign rd_over  = rd_fire && (rd_cnt == FULL);
  // Result arriving ahead of its input slice; compared on pre-edge counts.
  assign wr_early = wr_fire && (wr_cnt > rd_cnt);
  assign wr_last  = wr_fire && (wr_cnt == FULL - 1'b1);

  // ---------------- optional idle watchdog ----------------
`ifdef PERM_HOST_WATCHDOG_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] idle_cnt;

  // Trip on the edge where the count would reach TIMEOUT.
  assign wd_trip = (state == RUN) && !read_input && !write_output &&
                   (idle_cnt == TO - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          idle_cnt <= '0;
    else if (state != RUN || read_input || write_output) idle_cnt <= '0;
    else                                                 idle_cnt <= idle_cnt + 8'd1;
  end
`else
  assign wd_trip = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = START;
      START: if (st_cnt == 2'(START_LEN - 1)) state_nxt = RUN;
      RUN:   if (wr_last || wd_trip) state_nxt = DONE;
      DONE:  if (go) state_nxt = START;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_r <= 1'b0;
      st_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      start_r <= (state_nxt == START);
      st_cnt  <= (state == START) ? st_cnt + 2'd1 : 2'd0;
    end
  end

  // ---------------- pointers, counts, error ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_r  <= 1'b0;
    end else if (go_acc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      if (rd_fire && !rd_over) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_over || wr_early || wd_trip) err_r <= 1'b1;
    end
  end

  // ---------------- frame buffers (not reset) ----------------
  always_ff @(posedge clk) begin
    if (host_we && !busy) in_buf[host_waddr] <= host_wdata;
    if (wr_fire)          out_buf[wr_ptr]    <= slice_in;
  end

  assign slice_out  = in_buf[rd_ptr];
  assign host_rdata = out_buf[host_raddr];

endmodule

// File: doc/perm_host_agent.md
Name: perm_host_agent

Overview:
Host-side responder for the permutation control unit and its 6-bit slice counter. Holds a 64-slice input frame and pulses `start` to the controller. Serves one slice per `read_input` request and captures one result slice per `write_output` strobe. Exposes the captured 64-slice result frame to the system bus and reports completion via `done`.

Parameters:
SLICE_W, 25, bits per slice (5x5 lane bits of one z-slice)
DEPTH, 64, slices per frame
ADDR_W, 6, pointer/address width (log2 DEPTH)
TIMEOUT, 255, idle-cycle limit for optional watchdog (8-bit counter)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
host_we  in  1  write strobe into input frame buffer
host_waddr  in  ADDR_W  input frame slice address
host_wdata  in  SLICE_W  input frame slice data
host_raddr  in  ADDR_W  result frame slice address
host_rdata  out  SLICE_W  result frame slice, combinational read
go  in  1  request to run one permutation
busy  out  1  high from accepted go until DONE
done  out  1  frame complete, level
err  out  1  protocol error flag, sticky until next accepted go
start  out  1  to controller start input
read_input  in  1  controller requests next input slice
slice_out  out  SLICE_W  input slice presented to datapath
write_output  in  1  controller strobes a result slice
slice_in  in  SLICE_W  result slice from datapath

Behaviour:
- Reset (reset=0, async): FSM=IDLE; rd_ptr=0, wr_ptr=0, rd_cnt=0, wr_cnt=0; busy=0, done=0, err=0, start=0. Buffer RAMs are not cleared.
- Buffers: in_buf and out_buf, each DEPTH x SLICE_W.
- host_we writes in_buf[host_waddr] on the rising edge, only when busy=0. Writes while busy are ignored.
- host_rdata = out_buf[host_raddr] at all times.
- FSM state IDLE: start=0. On go=1, clear rd_ptr, wr_ptr, counts and err; drop done; go to START.
- FSM state START: start=1 for exactly START_LEN=2 cycles, then RUN. start is registered.
- FSM state RUN: start=0, busy=1.
- FSM state DONE: busy=0, done=1. Stays until go=1, which re-enters START as in IDLE. go in RUN is ignored.
- slice_out = in_buf[rd_ptr] combinationally. It is valid in any cycle where read_input=1.
- On an edge with read_input=1 in RUN: rd_ptr advances modulo DEPTH; rd_cnt increments.
- On an edge with write_output=1 in RUN: out_buf[wr_ptr] <= slice_in; wr_ptr advances; wr_cnt increments.
- read_input and write_output in the same cycle: both serviced independently in that cycle.
- wr_cnt reaching DEPTH (64th capture) moves RUN to DONE on that edge. done rises the next cycle.
- rd_ptr wraps 63 to 0. A read with rd_cnt already at DEPTH sets err=1; slice_out still shows in_buf[0]; no other effect.
- Any write_output with wr_cnt > rd_cnt (result slice before its input slice was read) sets err=1; the slice is still captured.
- read_input/write_output outside RUN: ignored; slice_out still tracks rd_ptr.
- Reset mid-RUN: immediate return to IDLE with all flags low. A partially written out_buf is retained.
- Counts are ADDR_W+1 bits wide so the value DEPTH is representable.

Optional Feature:
PERM_HOST_WATCHDOG_EN
- Defined: an 8-bit idle counter runs in RUN. It clears on any read_input or write_output. It increments otherwise. Reaching TIMEOUT sets err=1 and forces DONE.
- Undefined: no counter is compiled in; RUN waits indefinitely for 64 captures.

Test Plan:
- Load in_buf[i]=i*0x1F for i=0..63, pulse go. Required: start high exactly 2 cycles; busy=1 from the cycle after go.
- In RUN, drive read_input 64 consecutive cycles, write_output=1 from 1 cycle later with slice_in=~slice_out. Required: done=1 one cycle after the 64th write; out_buf[i]=~(i*0x1F) via host_raddr; err=0.
- Simultaneous read_input=write_output=1 each cycle after first read. Required: both pointers advance every cycle; no err.
- 65th read_input pulse before the final write. Required: err=1, slice_out=in_buf[0]; run still completes on the 64th write.
- Assert reset=0 mid-RUN after 20 writes, release, then read host_raddr=5. Required: busy=0, done=0, start=0 immediately; out_buf[5] retains its captured value.
- Watchdog (macro defined): go, then no controller activity for 255 cycles. Required: err=1, done=1. Macro undefined: busy stays 1 after 300 cycles.
